vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Parametrised raster timing generator, the successor to the fixed 640x480 controller. Produces H/V counters, sync, blanking, frame/line strobes and a line-prefetch request with explicit line number. Sits between pixel_clk and the line-buffer reader / HDMI encoder. Geometry, sync polarity and prefetch point are set by parameters; a run/stop input allows clean start-up.

Parameters:
HACT, 640, active pixels per line
HFP, 16, horizontal front porch (pixels)
HSYNC, 96, horizontal sync width (pixels)
HBP, 48, horizontal back porch (pixels)
VACT, 480, active lines per frame
VFP, 10, vertical front porch (lines)
VSYNC, 2, vertical sync width (lines)
VBP, 33, vertical back porch (lines)
HS_POL, 0, hs active level (0 = active low)
VS_POL, 0, vs active level (0 = active low)
REQ_X, HACT-1, hc value at which line_req fires
CW, 10, counter width; must hold HTOTAL-1 and VTOTAL-1 (HTOTAL = HACT+HFP+HSYNC+HBP, VTOTAL likewise)

Ports:
pixel_clk  in  1  pixel clock
reset  in  1  asynchronous, active-high
run  in  1  1 = counters advance; 0 = counters held at (0,0)
hs  out  1  horizontal sync, polarity HS_POL
vs  out  1  vertical sync, polarity VS_POL
active  out  1  high while hc<HACT and vc<VACT
v_blank  out  1  high while vc>=VACT
draw_x  out  CW  current hc
draw_y  out  CW  current vc
line_start  out  1  one-cycle pulse at hc==0
frame_start  out  1  one-cycle pulse at hc==0, vc==0
line_req  out  1  one-cycle prefetch pulse
line_req_y  out  CW  line index requested, valid while line_req

Behaviour:
- Reset: hc=vc=0; hs, vs at inactive level (!HS_POL / !VS_POL); line_req=0; frame_start, line_start driven per decode below but forced 0 while reset or run=0.
- Counters: when run=1 each cycle, hc increments; at hc==HTOTAL-1 hc->0 and vc increments; at vc==VTOTAL-1 together with hc wrap, vc->0. No other value is ever reachable.
- run=0: hc, vc synchronously cleared to 0 on next edge and held; hs/vs inactive; all pulses 0; active follows counters (high at (0,0)) but is gated low while run=0. On run rising, first cycle with run=1 shows (0,0) with frame_start=1.
- hs/vs registered from next-count value so they are aligned with draw_x/draw_y (no 1-cycle lag): hs active when hc in [HACT+HFP, HACT+HFP+HSYNC-1]; vs active when vc in [VACT+VFP, VACT+VFP+VSYNC-1], changing at hc==0 of the line.
- active, v_blank, line_start, frame_start, line_req: combinational decodes of registered hc/vc (glitch-free within a cycle not required).
- line_req: high when hc==REQ_X and the next line is active, i.e. vc==VTOTAL-1 or vc<=VACT-2. line_req_y = 0 when vc==VTOTAL-1, else vc+1. Exactly VACT requests per frame, indices 0..VACT-1 in order.
- Reset mid-frame: counters and registered outputs return to reset values immediately (async); no partial pulse is extended.
- Elaboration check: CW too small for HTOTAL/VTOTAL, or REQ_X>=HTOTAL, is a fatal elaboration error.

Optional Feature:
VGA_TIMING_FRAME_CNT_EN: when defined, adds output frame_cnt (16 bits), reset 0, incremented by 1 on every frame_start pulse, wraps 0xFFFF->0; held while run=0. When undefined the port does not exist and no counter logic is generated.

Test Plan:
- Defaults, run=1 from reset: hc period 800, vc period 525 (420000 cycles/frame); frame_start once per 420000 cycles.
- Defaults: hs low exactly for draw_x 656..751 on every line; vs low exactly for draw_y 490..491, transitioning at draw_x==0.
- Defaults: line_req fires at draw_x==639 on draw_y 524 (req_y=0) and 0..478 (req_y 1..479); 480 pulses/frame, none on lines 479..523.
- HS_POL=1, VS_POL=1, HACT=800, HFP=40, HSYNC=128, HBP=88, VACT=600, VFP=1, VSYNC=4, VBP=23, CW=11: hs high for draw_x 840..967, HTOTAL 1056, VTOTAL 628.
- Assert reset at (300,200), release, run=1: outputs resume at (0,0) with frame_start=1, hs/vs inactive; drop run for 50 cycles mid-line: counters 0, no pulses, restart at (0,0).
- With VGA_TIMING_FRAME_CNT_EN: after 3 full frames frame_cnt==3 (first frame_start counts as 1 after reset then increments); preload-free wrap check via forced 0xFFFF -> 0.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator.
// Produces H/V counters, registered hs/vs aligned with draw_x/draw_y,
// blanking/active decodes, line/frame strobes and a line-prefetch request.
// Optional build macro VGA_TIMING_FRAME_CNT_EN adds a 16-bit frame counter
// output (frame_cnt); without it the port and its logic do not exist.
module vga_timing_gen #(
    parameter int HACT   = 640,
    parameter int HFP    = 16,
    parameter int HSYNC  = 96,
    parameter int HBP    = 48,
    parameter int VACT   = 480,
    parameter int VFP    = 10,
    parameter int VSYNC  = 2,
    parameter int VBP    = 33,
    parameter bit HS_POL = 1'b0,
    parameter bit VS_POL = 1'b0,
    parameter int REQ_X  = HACT - 1,
    parameter int CW     = 10
) (
    input  logic          pixel_clk,
    input  logic          reset,
    input  logic          run,
    output logic          hs,
    output logic          vs,
    output logic          active,
    output logic          v_blank,
    output logic [CW-1:0] draw_x,
    output logic [CW-1:0] draw_y,
    output logic          line_start,
    output logic          frame_start,
    output logic          line_req,
    output logic [CW-1:0] line_req_y
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0]   frame_cnt
`endif
);

    localparam int HTOTAL = HACT + HFP + HSYNC + HBP;
    localparam int VTOTAL = VACT + VFP + VSYNC + VBP;

    localparam logic [CW-1:0] H_LAST     = CW'(HTOTAL - 1);
    localparam logic [CW-1:0] V_LAST     = CW'(VTOTAL - 1);
    localparam logic [CW-1:0] H_ACT      = CW'(HACT);
    localparam logic [CW-1:0] V_ACT      = CW'(VACT);
    localparam logic [CW-1:0] HS_FIRST   = CW'(HACT + HFP);
    localparam logic [CW-1:0] HS_LAST    = CW'(HACT + HFP + HSYNC - 1);
    localparam logic [CW-1:0] VS_FIRST   = CW'(VACT + VFP);
    localparam logic [CW-1:0] VS_LAST    = CW'(VACT + VFP + VSYNC - 1);
    localparam logic [CW-1:0] H_REQ      = CW'(REQ_X);
    localparam logic [CW-1:0] V_REQ_LAST = CW'(VACT - 2);

    // A geometry the counters cannot represent must never build silently.
    if ((HTOTAL - 1) >= (1 << CW) || (VTOTAL - 1) >= (1 << CW) ||
        REQ_X >= HTOTAL || REQ_X < 0) begin : g_cfg_check
        $fatal(1, "vga_timing_gen: CW too small for HTOTAL/VTOTAL or REQ_X out of range");
    end

    logic [CW-1:0] r_hc;
    logic [CW-1:0] r_vc;
    logic          r_hs;
    logic          r_vs;

    logic [CW-1:0] w_hc_next;
    logic [CW-1:0] w_vc_next;
    logic          w_h_wrap;
    logic          w_hs_next;
    logic          w_vs_next;
    logic          w_go;

    // Next raster position: advance while running, collapse to (0,0) when stopped.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        w_h_wrap  = (r_hc == H_LAST);
        w_hc_next = '0;
        w_vc_next = '0;
        if (run) begin
            w_hc_next = w_h_wrap ? '0 : r_hc + 1'b1;
            w_vc_next = r_vc;
            if (w_h_wrap) begin
                w_vc_next = (r_vc == V_LAST) ? '0 : r_vc + 1'b1;
            end
        end
    end

    // Sync levels decoded from the next position so the registered syncs line up with the counters.
    always_comb begin
        w_hs_next = ((w_hc_next >= HS_FIRST) && (w_hc_next <= HS_LAST)) ? HS_POL : ~HS_POL;
        w_vs_next = ((w_vc_next >= VS_FIRST) && (w_vc_next <= VS_LAST)) ? VS_POL : ~VS_POL;
    end

    // Raster state and sync registers; async reset parks at (0,0) with syncs inactive.
    always_ff @(posedge pixel_clk or posedge reset) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            r_hc <= '0;
            r_vc <= '0;
            r_hs <= ~HS_POL;
            r_vs <= ~VS_POL;
        end else begin
            r_hc <= w_hc_next;
            r_vc <= w_vc_next;
            r_hs <= w_hs_next;
            r_vs <= w_vs_next;
        end
    end

    // Strobes are suppressed whenever the generator is stopped or held in reset.
    assign w_go        = run & ~reset;

    assign hs          = r_hs;
    assign vs          = r_vs;
    assign draw_x      = r_hc;
    assign draw_y      = r_vc;
    assign active      = run && (r_hc < H_ACT) && (r_vc < V_ACT);
    assign v_blank     = (r_vc >= V_ACT);
    assign line_start  = w_go && (r_hc == '0);
    assign frame_start = w_go && (r_hc == '0) && (r_vc == '0);

    // Prefetch fires on the line before each active line; the last line of the frame requests line 0.
    assign line_req    = w_go && (r_hc == H_REQ) &&
                         ((r_vc == V_LAST) || ((VACT >= 2) && (r_vc <= V_REQ_LAST)));
    assign line_req_y  = (r_vc == V_LAST) ? '0 : r_vc + 1'b1;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    // Count frame_start pulses; wraps naturally at 16 bits and holds while stopped.
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            r_frame_cnt <= '0;
        end else if (frame_start) begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: three generator instances (default 640x480 timing, a
// small active-low geometry and a small active-high geometry with a blanking
// prefetch point) driven by shared random run/reset stimulus and compared
// each cycle against a raster model built from the elapsed pixel count.
module tb_vga_timing_gen;

    typedef struct {
        int hact, hfp, hsync, hbp;
        int vact, vfp, vsync, vbp;
        int hpol, vpol, reqx;
    } geom_t;

    typedef struct {
        logic [31:0] x, y, hs, vs, act, vb, ls, fs, lr, lry;
    } out_t;

    logic pixel_clk;
    logic rst;
    logic run_i;

    logic [2:0] hs_o, vs_o, act_o, vb_o, ls_o, fs_o, lr_o;
    logic [9:0] x0, y0, ry0;
    logic [5:0] x1, y1, ry1;
    logic [3:0] x2, y2, ry2;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] fc0, fc1, fc2;
`endif

    geom_t G [3];
    int    t [3];
    int    n_tests = 0;
    int    n_fail  = 0;

    bit    counting = 1'b0;
    int    cnt_lr [3];
    int    cnt_fs [3];
    int    cnt_hs [3];
    int    cnt_vs [3];
    int    next_idx [3];

    vga_timing_gen u_dut0 (
        .pixel_clk(pixel_clk), .reset(rst), .run(run_i),
        .hs(hs_o[0]), .vs(vs_o[0]), .active(act_o[0]), .v_blank(vb_o[0]),
        .draw_x(x0), .draw_y(y0), .line_start(ls_o[0]), .frame_start(fs_o[0]),
        .line_req(lr_o[0]), .line_req_y(ry0)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_cnt(fc0)
`endif
    );

    vga_timing_gen #(
        .HACT(8), .HFP(2), .HSYNC(3), .HBP(3),
        .VACT(5), .VFP(1), .VSYNC(2), .VBP(2), .CW(6)
    ) u_dut1 (
        .pixel_clk(pixel_clk), .reset(rst), .run(run_i),
        .hs(hs_o[1]), .vs(vs_o[1]), .active(act_o[1]), .v_blank(vb_o[1]),
        .draw_x(x1), .draw_y(y1), .line_start(ls_o[1]), .frame_start(fs_o[1]),
        .line_req(lr_o[1]), .line_req_y(ry1)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_cnt(fc1)
`endif
    );

    vga_timing_gen #(
        .HACT(6), .HFP(1), .HSYNC(2), .HBP(2),
        .VACT(4), .VFP(2), .VSYNC(1), .VBP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .REQ_X(9), .CW(4)
    ) u_dut2 (
        .pixel_clk(pixel_clk), .reset(rst), .run(run_i),
        .hs(hs_o[2]), .vs(vs_o[2]), .active(act_o[2]), .v_blank(vb_o[2]),
        .draw_x(x2), .draw_y(y2), .line_start(ls_o[2]), .frame_start(fs_o[2]),
        .line_req(lr_o[2]), .line_req_y(ry2)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_cnt(fc2)
`endif
    );

    initial pixel_clk = 1'b0;
    always #5 pixel_clk = ~pixel_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 20) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int htot(input int i);
        return G[i].hact + G[i].hfp + G[i].hsync + G[i].hbp;
    endfunction

    function automatic int vtot(input int i);
        return G[i].vact + G[i].vfp + G[i].vsync + G[i].vbp;
    endfunction

    // Reference: position is simply elapsed run cycles folded onto the raster.
    function automatic out_t model(input int i);
        out_t e;
        int   hc, vc, hs_lo, vs_lo;
        logic go;
        hc    = t[i] % htot(i);
        vc    = t[i] / htot(i);
        go    = run_i && !rst;
        hs_lo = G[i].hact + G[i].hfp;
        vs_lo = G[i].vact + G[i].vfp;
        e.x   = hc;
        e.y   = vc;
        e.hs  = (hc >= hs_lo && hc < hs_lo + G[i].hsync) ? G[i].hpol : 1 - G[i].hpol;
        e.vs  = (vc >= vs_lo && vc < vs_lo + G[i].vsync) ? G[i].vpol : 1 - G[i].vpol;
        e.act = 32'(run_i && hc < G[i].hact && vc < G[i].vact);
        e.vb  = 32'(vc >= G[i].vact);
        e.ls  = 32'(go && hc == 0);
        e.fs  = 32'(go && hc == 0 && vc == 0);
        e.lr  = 32'(go && hc == G[i].reqx && (vc == vtot(i) - 1 || vc + 1 < G[i].vact));
        e.lry = (vc + 1) % vtot(i);
        return e;
    endfunction

    function automatic out_t get_obs(input int i);
        out_t o;
        o.hs  = 32'(hs_o[i]);
        o.vs  = 32'(vs_o[i]);
        o.act = 32'(act_o[i]);
        o.vb  = 32'(vb_o[i]);
        o.ls  = 32'(ls_o[i]);
        o.fs  = 32'(fs_o[i]);
        o.lr  = 32'(lr_o[i]);
        case (i)
            0:       begin o.x = 32'(x0); o.y = 32'(y0); o.lry = 32'(ry0); end
            1:       begin o.x = 32'(x1); o.y = 32'(y1); o.lry = 32'(ry1); end
            default: begin o.x = 32'(x2); o.y = 32'(y2); o.lry = 32'(ry2); end
        endcase
        return o;
    endfunction

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            out_t o, e;
            o = get_obs(i);
            e = model(i);
            check($sformatf("u%0d.draw_x", i), o.x, e.x);
            check($sformatf("u%0d.draw_y", i), o.y, e.y);
            check($sformatf("u%0d.hs", i), o.hs, e.hs);
            check($sformatf("u%0d.vs", i), o.vs, e.vs);
            check($sformatf("u%0d.active", i), o.act, e.act);
            check($sformatf("u%0d.v_blank", i), o.vb, e.vb);
            check($sformatf("u%0d.line_start", i), o.ls, e.ls);
            check($sformatf("u%0d.frame_start", i), o.fs, e.fs);
            check($sformatf("u%0d.line_req", i), o.lr, e.lr);
            if (e.lr[0]) check($sformatf("u%0d.line_req_y", i), o.lry, e.lry);
            if (counting) begin
                cnt_lr[i] += int'(o.lr);
                cnt_fs[i] += int'(o.fs);
                cnt_hs[i] += (o.hs == 32'(G[i].hpol)) ? 1 : 0;
                cnt_vs[i] += (o.vs == 32'(G[i].vpol)) ? 1 : 0;
                if (o.lr[0]) begin
                    check($sformatf("u%0d.req_order", i), o.lry, 32'(next_idx[i]));
                    next_idx[i] = (next_idx[i] + 1) % G[i].vact;
                end
            end
        end
    endtask

    // One pixel clock: drive at negedge, check 1 ns later, advance the model at posedge.
    task automatic step(input logic r, input logic rs);
        @(negedge pixel_clk);
        run_i = r;
        rst   = rs;
        if (rs) for (int i = 0; i < 3; i++) t[i] = 0;
        #1;
        check_all();
        @(posedge pixel_clk);
        if (!rs) begin
            for (int i = 0; i < 3; i++) t[i] = r ? (t[i] + 1) % (htot(i) * vtot(i)) : 0;
        end
    endtask

    initial begin
        int exp_lr [3];
        int exp_fs [3];
        int exp_hs [3];
        int exp_vs [3];
        logic r;

        G[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 639};
        G[1] = '{8, 2, 3, 3, 5, 1, 2, 2, 0, 0, 7};
        G[2] = '{6, 1, 2, 2, 4, 2, 1, 1, 1, 1, 9};
        for (int i = 0; i < 3; i++) t[i] = 0;

        // 1760 cycles from (0,0): default = 2 lines + 160 px, u1 = 11 frames, u2 = 20 frames.
        exp_lr = '{2, 55, 80};
        exp_fs = '{1, 11, 20};
        exp_hs = '{192, 330, 320};
        exp_vs = '{0, 352, 220};

        rst   = 1'b1;
        run_i = 1'b0;
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);

        for (int i = 0; i < 3; i++) begin
            cnt_lr[i] = 0; cnt_fs[i] = 0; cnt_hs[i] = 0; cnt_vs[i] = 0;
            next_idx[i] = 1;
        end
        counting = 1'b1;
        for (int c = 0; c < 1760; c++) step(1'b1, 1'b0);
        counting = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("u%0d.req_count", i), 32'(cnt_lr[i]), 32'(exp_lr[i]));
            check($sformatf("u%0d.frame_count", i), 32'(cnt_fs[i]), 32'(exp_fs[i]));
            check($sformatf("u%0d.hs_cycles", i), 32'(cnt_hs[i]), 32'(exp_hs[i]));
            check($sformatf("u%0d.vs_cycles", i), 32'(cnt_vs[i]), 32'(exp_vs[i]));
        end

`ifdef VGA_TIMING_FRAME_CNT_EN
        #1;
        check("u0.frame_cnt", 32'(fc0), 32'd1);
        check("u1.frame_cnt", 32'(fc1), 32'd11);
        check("u2.frame_cnt", 32'(fc2), 32'd20);
        #1;
        force u_dut1.r_frame_cnt = 16'hFFFF;
        #1;
        release u_dut1.r_frame_cnt;
        step(1'b1, 1'b0);
        #1;
        check("u1.frame_cnt_wrap", 32'(fc1), 32'd0);
`endif

        // Stop mid-line for 50 cycles, then restart from (0,0).
        for (int c = 0; c < 50; c++) step(1'b0, 1'b0);
        for (int c = 0; c < 40; c++) step(1'b1, 1'b0);

        // Random run drops and asynchronous resets mid-frame.
        r = 1'b1;
        for (int c = 0; c < 8000; c++) begin
            if (r) begin
                if ($urandom_range(299) == 0) r = 1'b0;
            end else if ($urandom_range(19) == 0) begin
                r = 1'b1;
            end
            step(r, ($urandom_range(399) == 0) ? 1'b1 : 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
